// File: rtl/y86_pipe_pkg.sv
// Shared Y86-64 pipeline constants: icodes, status codes, RNONE and the
// hazard-controller state encoding.
package y86_pipe_pkg;
    localparam int I_HALT   = 0;
    localparam int I_NOP    = 1;
    localparam int I_RRMOVQ = 2;
    localparam int I_IRMOVQ = 3;
    localparam int I_RMMOVQ = 4;
    localparam int I_MRMOVQ = 5;
    localparam int I_OPQ    = 6;
    localparam int I_JXX    = 7;
    localparam int I_CALL   = 8;
    localparam int I_RET    = 9;
    localparam int I_PUSHQ  = 10;
    localparam int I_POPQ   = 11;

    localparam int S_AOK = 1;
    localparam int S_HLT = 2;
    localparam int S_ADR = 3;
    localparam int S_INS = 4;

    localparam int RNONE = 15;

    typedef enum logic [1:0] {RUN, WAIT_MEM, HALTED} state_t;
endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load/use, ret and jXX-mispredict detection; shared with the
// forwarding unit.
module pipe_hazard_detect
    import y86_pipe_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4
) (
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic               e_cnd,
    output logic               lu,
    output logic               ret,
    output logic               mp
);
    logic e_load;

    assign e_load = (E_icode == ICODE_W'(I_MRMOVQ)) || (E_icode == ICODE_W'(I_POPQ));
    // RNONE is all-ones at whatever register-ID width is configured
    assign lu  = e_load && (E_dstM != {REG_W{1'b1}}) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret = (D_icode == ICODE_W'(I_RET)) || (E_icode == ICODE_W'(I_RET)) ||
                 (M_icode == ICODE_W'(I_RET));
    assign mp  = (E_icode == ICODE_W'(I_JXX)) && !e_cnd;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline stall/bubble controller with data-memory wait watchdog and
// sticky halt. Define PIPE_HAZARD_PERF_EN to add saturating hazard counters.
module pipe_hazard_ctrl
    import y86_pipe_pkg::*;
#(
    parameter int ICODE_W     = 4,
    parameter int REG_W       = 4,
    parameter int STAT_W      = 4,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               M_memop,
    input  logic               dmem_ready,
    output logic               F_stall,
    output logic               D_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               M_stall,
    output logic               W_stall,
    output logic               W_bubble,
    output logic               proc_halted,
    output logic [STAT_W-1:0]  halt_stat,
    output logic               mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]   cnt_lu,
    output logic [CNT_W-1:0]   cnt_ret,
    output logic [CNT_W-1:0]   cnt_mp,
    output logic [CNT_W-1:0]   cnt_memwait
`endif
);
    if (MEM_TIMEOUT >= (1 << TMO_W) || CNT_W < 1) begin : g_bad_cfg
        $error("pipe_hazard_ctrl: MEM_TIMEOUT must fit in TMO_W bits");
    end

    state_t            state, state_nx;
    logic [TMO_W-1:0]  wd, wd_nx;
    logic [STAT_W-1:0] hstat, hstat_nx;
    logic              tmo, tmo_nx;
    logic              lu, ret, mp;
    logic              w_exc, m_exc, mw;
    logic              take_exc, hold_mem, normal, halted;

    pipe_hazard_detect #(.ICODE_W(ICODE_W), .REG_W(REG_W)) u_detect (
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
        .lu(lu), .ret(ret), .mp(mp)
    );

    assign w_exc = (W_stat != STAT_W'(S_AOK));
    assign m_exc = (m_stat != STAT_W'(S_AOK));
    assign mw    = M_memop && !dmem_ready && !m_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wd    <= '0;
            hstat <= STAT_W'(S_AOK);
            tmo   <= 1'b0;
        end else begin
            state <= state_nx;
            wd    <= wd_nx;
            hstat <= hstat_nx;
            tmo   <= tmo_nx;
        end
    end

    // Pick exactly one output regime per cycle; the output equations below
    // are written purely in terms of these four flags.
    always_comb begin
        state_nx = state;
        wd_nx    = wd;
        hstat_nx = hstat;
        tmo_nx   = tmo;
        take_exc = 1'b0;
        hold_mem = 1'b0;
        normal   = 1'b0;
        halted   = 1'b0;
        case (state)
            RUN: begin
                if (w_exc) begin
                    take_exc = 1'b1;
                    state_nx = HALTED;
                    hstat_nx = W_stat;
                end else if (mw) begin
                    hold_mem = 1'b1;
                    state_nx = WAIT_MEM;
                    wd_nx    = TMO_W'(1);
                end else begin
                    normal = 1'b1;
                end
            end
            WAIT_MEM: begin
                if (w_exc) begin
                    take_exc = 1'b1;
                    state_nx = HALTED;
                    hstat_nx = W_stat;
                end else if (wd == TMO_W'(MEM_TIMEOUT)) begin
                    hold_mem = 1'b1;
                    state_nx = HALTED;
                    hstat_nx = STAT_W'(S_ADR);
                    tmo_nx   = 1'b1;
                end else if (dmem_ready) begin
                    normal   = 1'b1;
                    state_nx = RUN;
                    wd_nx    = '0;
                end else begin
                    hold_mem = 1'b1;
                    wd_nx    = wd + TMO_W'(1);
                end
            end
            HALTED:  halted = 1'b1;
            default: state_nx = RUN;
        endcase
    end

    // Outputs are gated by rst_n so they read zero for the whole reset pulse.
    assign F_stall     = rst_n & (take_exc | hold_mem | halted | (normal & (lu | ret)));
    assign D_stall     = rst_n & (take_exc | hold_mem | halted | (normal & lu));
    assign D_bubble    = rst_n & normal & (mp | (ret & !lu));
    assign E_bubble    = rst_n & (take_exc | (normal & (mp | lu)));
    assign M_bubble    = rst_n & (take_exc | (normal & m_exc));
    assign M_stall     = rst_n & (hold_mem | halted);
    assign W_stall     = rst_n & (take_exc | halted);
    assign W_bubble    = rst_n & hold_mem;
    assign proc_halted = rst_n & (state == HALTED);
    assign halt_stat   = rst_n ? hstat : '0;
    assign mem_timeout = rst_n & tmo;

`ifdef PIPE_HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    // normal/hold_mem are never set in HALTED, so the counters freeze there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lu      <= '0;
            cnt_ret     <= '0;
            cnt_mp      <= '0;
            cnt_memwait <= '0;
        end else begin
            cnt_lu      <= sat_inc(cnt_lu, normal & lu);
            cnt_ret     <= sat_inc(cnt_ret, normal & ret);
            cnt_mp      <= sat_inc(cnt_mp, normal & mp);
            cnt_memwait <= sat_inc(cnt_memwait, hold_mem);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (default watchdog and
// MEM_TIMEOUT=4) checked every cycle against a rule-level model.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, m_stat, W_stat;
    logic       e_cnd, M_memop, dmem_ready;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, M_stall, W_stall, W_bubble}
    logic [7:0] ctl_a, ctl_b;
    logic       ph_a, ph_b, mt_a, mt_b;
    logic [3:0] hs_a, hs_b;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] c_lu, c_ret, c_mp, c_mw, cb_lu, cb_ret, cb_mp, cb_mw;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
        .m_stat(m_stat), .W_stat(W_stat), .M_memop(M_memop), .dmem_ready(dmem_ready),
        .F_stall(ctl_a[7]), .D_stall(ctl_a[6]), .D_bubble(ctl_a[5]), .E_bubble(ctl_a[4]),
        .M_bubble(ctl_a[3]), .M_stall(ctl_a[2]), .W_stall(ctl_a[1]), .W_bubble(ctl_a[0]),
        .proc_halted(ph_a), .halt_stat(hs_a), .mem_timeout(mt_a)
`ifdef PIPE_HAZARD_PERF_EN
        , .cnt_lu(c_lu), .cnt_ret(c_ret), .cnt_mp(c_mp), .cnt_memwait(c_mw)
`endif
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_cnd(e_cnd),
        .m_stat(m_stat), .W_stat(W_stat), .M_memop(M_memop), .dmem_ready(dmem_ready),
        .F_stall(ctl_b[7]), .D_stall(ctl_b[6]), .D_bubble(ctl_b[5]), .E_bubble(ctl_b[4]),
        .M_bubble(ctl_b[3]), .M_stall(ctl_b[2]), .W_stall(ctl_b[1]), .W_bubble(ctl_b[0]),
        .proc_halted(ph_b), .halt_stat(hs_b), .mem_timeout(mt_b)
`ifdef PIPE_HAZARD_PERF_EN
        , .cnt_lu(cb_lu), .cnt_ret(cb_ret), .cnt_mp(cb_mp), .cnt_memwait(cb_mw)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         md [2];   // 0 running, 1 waiting on memory, 2 halted
    int         wt [2];   // wait cycles elapsed
    logic [3:0] mhs [2];
    logic       mto [2];
    int         m_lu, m_ret, m_mp, m_mw;

    function automatic int lim_of(int k);
        return (k == 0) ? 200 : 4;
    endfunction

    function automatic logic f_lu();
        return (E_icode == 4'd5 || E_icode == 4'hB) && E_dstM != 4'hF &&
               (E_dstM == d_srcA || E_dstM == d_srcB);
    endfunction
    function automatic logic f_ret();
        return D_icode == 4'd9 || E_icode == 4'd9 || M_icode == 4'd9;
    endfunction
    function automatic logic f_mp();
        return E_icode == 4'd7 && !e_cnd;
    endfunction

    // 0 halted, 1 exception freeze, 2 memory hold, 3 ordinary hazard rules
    function automatic int kind(int k);
        if (md[k] == 2) return 0;
        if (W_stat != 4'd1) return 1;
        if (md[k] == 1) begin
            if (wt[k] == lim_of(k)) return 2;
            return dmem_ready ? 3 : 2;
        end
        return (M_memop && !dmem_ready && m_stat == 4'd1) ? 2 : 3;
    endfunction

    function automatic logic [7:0] exp_ctl(int k);
        logic l, r, p;
        l = f_lu(); r = f_ret(); p = f_mp();
        case (kind(k))
            0:       return 8'b1100_0110;
            1:       return 8'b1101_1010;
            2:       return 8'b1100_0101;
            default: return {l | r, l, p | (r & !l), p | l, m_stat != 4'd1, 3'b000};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                md[k] <= 0; wt[k] <= 0; mhs[k] <= 4'd1; mto[k] <= 1'b0;
            end
            m_lu <= 0; m_ret <= 0; m_mp <= 0; m_mw <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (kind(k))
                    1: begin md[k] <= 2; mhs[k] <= W_stat; end
                    2: if (md[k] == 1 && wt[k] == lim_of(k)) begin
                           md[k] <= 2; mhs[k] <= 4'd3; mto[k] <= 1'b1;
                       end else begin
                           md[k] <= 1; wt[k] <= wt[k] + 1;
                       end
                    3: begin md[k] <= 0; wt[k] <= 0; end
                    default: ;
                endcase
            end
            if (kind(0) == 2) m_mw <= m_mw + 1;
            if (kind(0) == 3) begin
                m_lu <= m_lu + int'(f_lu());
                m_ret <= m_ret + int'(f_ret());
                m_mp <= m_mp + int'(f_mp());
            end
        end
    end

    always @(negedge clk) begin
        chk("ctl_a", 32'(ctl_a), rst_n ? 32'(exp_ctl(0)) : 32'd0);
        chk("ctl_b", 32'(ctl_b), rst_n ? 32'(exp_ctl(1)) : 32'd0);
        chk("halted_a", 32'(ph_a), 32'(rst_n && md[0] == 2));
        chk("halted_b", 32'(ph_b), 32'(rst_n && md[1] == 2));
        chk("hstat_a", 32'(hs_a), rst_n ? 32'(mhs[0]) : 32'd0);
        chk("hstat_b", 32'(hs_b), rst_n ? 32'(mhs[1]) : 32'd0);
        chk("tmo_a", 32'(mt_a), 32'(rst_n && mto[0]));
        chk("tmo_b", 32'(mt_b), 32'(rst_n && mto[1]));
`ifdef PIPE_HAZARD_PERF_EN
        chk("cnt_lu", c_lu, m_lu);
        chk("cnt_ret", c_ret, m_ret);
        chk("cnt_mp", c_mp, m_mp);
        chk("cnt_memwait", c_mw, m_mw);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_cnd = 1'b1; m_stat = 4'd1; W_stat = 4'd1;
        M_memop = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic go();
        @(posedge clk); #1;
    endtask

    task automatic mid_reset();
        go(); #3;
        rst_n = 1'b0; #1;
        chk("rst_now_ctl_a", 32'(ctl_a), 32'd0);
        chk("rst_now_ctl_b", 32'(ctl_b), 32'd0);
        chk("rst_now_halted", 32'({ph_a, ph_b}), 32'd0);
        chk("rst_now_hstat", 32'(hs_a), 32'd0);
        #3; rst_n = 1'b1; #1;
        chk("rel_halted", 32'({ph_a, ph_b}), 32'd0);
        chk("rel_hstat", 32'(hs_b), 32'd1);
        chk("rel_tmo", 32'(mt_b), 32'd0);
    endtask

    initial begin
        idle();
        #12;
        chk("reset_ctl", 32'(ctl_a), 32'd0);
        chk("reset_hstat", 32'(hs_a), 32'd0);
        #10; rst_n = 1'b1; #1;
        chk("post_reset_hstat", 32'(hs_a), 32'd1);
        chk("post_reset_halted", 32'(ph_a), 32'd0);

        // load/use, then same with RNONE destination
        go(); E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        @(negedge clk); chk("loaduse", 32'(ctl_a), 32'hD0);
        go(); E_dstM = 4'hF;
        @(negedge clk); chk("loaduse_rnone", 32'(ctl_a), 32'h00);

        // ret walking D -> E -> M
        go(); idle(); D_icode = 4'd9;
        @(negedge clk); chk("ret_d", 32'(ctl_a), 32'hA0);
        go(); D_icode = 4'd1; E_icode = 4'd9;
        @(negedge clk); chk("ret_e", 32'(ctl_a), 32'hA0);
        go(); E_icode = 4'd1; M_icode = 4'd9;
        @(negedge clk); chk("ret_m", 32'(ctl_a), 32'hA0);
        go(); M_icode = 4'd1;
        @(negedge clk); chk("ret_gone", 32'(ctl_a), 32'h00);

        // mispredict; load/use with ret; faulting M access never waits
        go(); E_icode = 4'd7; e_cnd = 1'b0;
        @(negedge clk); chk("mispredict", 32'(ctl_a), 32'h30);
        go(); idle(); E_icode = 4'hB; E_dstM = 4'd3; d_srcB = 4'd3; D_icode = 4'd9;
        @(negedge clk); chk("lu_ret", 32'(ctl_a), 32'hD0);
        go(); idle(); m_stat = 4'd3; M_memop = 1'b1; dmem_ready = 1'b0;
        @(negedge clk); chk("m_exc_no_wait", 32'(ctl_a), 32'h08);

        // 5-cycle memory wait; dut_b's watchdog (4) expires meanwhile
        go(); idle(); M_memop = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("memwait_hold", 32'(ctl_a), 32'hC5);
            go();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("memwait_release", 32'(ctl_a), 32'h00);
        chk("wdog_halted", 32'(ph_b), 32'd1);
        chk("wdog_hstat", 32'(hs_b), 32'd3);
        chk("wdog_tmo", 32'(mt_b), 32'd1);
`ifdef PIPE_HAZARD_PERF_EN
        chk("memwait_count", c_mw, 32'd5);
`endif
        go(); M_memop = 1'b0;
        @(negedge clk); chk("memwait_run", 32'({ph_a, ctl_a}), 32'h000);

        mid_reset();

        // exception while waiting beats dmem_ready
        go(); idle(); M_memop = 1'b1; dmem_ready = 1'b0;
        go(); W_stat = 4'd3; dmem_ready = 1'b1;
        @(negedge clk); chk("wait_exc", 32'(ctl_a), 32'hDA);
        go(); idle();
        @(negedge clk);
        chk("wait_exc_halt", 32'({ph_a, hs_a, mt_a}), 32'b1_0011_0);
        chk("halted_ctl", 32'(ctl_a), 32'hC6);

        mid_reset();

        // HLT in W, then sticky halt
        go(); idle(); W_stat = 4'd2;
        @(negedge clk); chk("hlt_exc", 32'(ctl_a), 32'hDA);
        go(); W_stat = 4'd1;
        @(negedge clk); chk("hlt_halted", 32'({ph_a, hs_a}), 32'h12);
        go(); E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        @(negedge clk); chk("hlt_sticky", 32'({ph_a, ctl_a}), 32'h1C6);

        mid_reset();
        go(); idle();
        @(negedge clk); chk("after_reset_run", 32'({ph_a, hs_a, ctl_a}), 32'h0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
